// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial unsigned A - B - Bin, LSB first, one bit per clock with a single borrow flip-flop
module serial_subtractor #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             Bout
);
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t           state_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] a_q, b_q, diff_q;
  logic             br_q, busy_q, done_q, bout_q;
  logic             d_bit, br_d, last;
  always_comb begin
    d_bit = a_q[0] ^ b_q[0] ^ br_q;
    br_d  = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & br_q);
    last  = cnt_q == CW'(WIDTH - 1);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      diff_q  <= '0;
      br_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      bout_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (start) begin
          state_q <= SHIFT;
          a_q     <= A;
          b_q     <= B;
          br_q    <= Bin;
          cnt_q   <= '0;
          busy_q  <= 1'b1;
        end
        SHIFT: begin
          // result enters at the MSB so bit i has moved down to diff[i] after WIDTH shifts
          diff_q <= {d_bit, diff_q[WIDTH-1:1]};
          a_q    <= a_q >> 1;
          b_q    <= b_q >> 1;
          br_q   <= br_d;
          cnt_q  <= last ? cnt_q : cnt_q + CW'(1);
          if (last) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            bout_q  <= br_d;
          end
        end
        default: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
        end
      endcase
    end
  end
  assign busy = busy_q;
  assign done = done_q;
  assign diff = diff_q;
  assign Bout = bout_q;
endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: directed and exhaustive checks of the bit-serial subtractor at WIDTH 4 and 8
module tb_serial_subtractor;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start4 = 1'b0, start8 = 1'b0;
  logic [3:0] a4 = '0, b4 = '0;
  logic [7:0] a8 = '0, b8 = '0;
  logic       bin4 = 1'b0, bin8 = 1'b0;
  logic       busy4, done4, bout4, busy8, done8, bout8;
  logic [3:0] diff4;
  logic [7:0] diff8;
  int         total = 0, bad = 0, cyc = 0;

  serial_subtractor #(.WIDTH(4)) u4 (
    .clk(clk), .rst(rst), .start(start4), .A(a4), .B(b4), .Bin(bin4),
    .busy(busy4), .done(done4), .diff(diff4), .Bout(bout4)
  );
  serial_subtractor #(.WIDTH(8)) u8 (
    .clk(clk), .rst(rst), .start(start8), .A(a8), .B(b8), .Bin(bin8),
    .busy(busy8), .done(done8), .diff(diff8), .Bout(bout8)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run4(input string tag, input logic [3:0] a, input logic [3:0] b, input logic bin,
                      input logic [3:0] ed, input logic eb);
    int nb;
    a4 = a; b4 = b; bin4 = bin; start4 = 1'b1;
    tick();
    start4 = 1'b0;
    nb = 0;
    for (int i = 0; i < 12; i++) begin
      if (done4) break;
      nb += int'(busy4);
      tick();
    end
    chk({tag, "_busy_cycles"}, nb, 4);
    chk({tag, "_done"}, done4, 1);
    chk({tag, "_busy_at_done"}, busy4, 0);
    chk({tag, "_diff"}, diff4, ed);
    chk({tag, "_bout"}, bout4, eb);
    tick();
    chk({tag, "_done_one_cycle"}, done4, 0);
  endtask

  initial begin
    logic [4:0] t;
    logic [3:0] ca, cb;
    logic       cbin;
    int         prev, nb;
    start4 = 1'b1;
    tick();
    tick();
    chk("rst_busy", busy4, 0);
    chk("rst_done", done4, 0);
    chk("rst_diff", diff4, 0);
    chk("rst_bout", bout4, 0);
    chk("rst_diff8", diff8, 0);
    rst = 1'b0;
    start4 = 1'b0;
    tick();
    chk("start_with_rst_dropped", busy4, 0);

    run4("a9b3", 4'd9, 4'd3, 1'b0, 4'd6, 1'b0);
    run4("a3b9", 4'd3, 4'd9, 1'b0, 4'd10, 1'b1);
    run4("a0b0bin1", 4'd0, 4'd0, 1'b1, 4'd15, 1'b1);
    run4("a15b15", 4'd15, 4'd15, 1'b0, 4'd0, 1'b0);

    // abort on the second SHIFT cycle
    a4 = 4'd9; b4 = 4'd3; bin4 = 1'b0; start4 = 1'b1;
    tick();
    start4 = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_busy", busy4, 0);
    chk("abort_diff", diff4, 0);
    chk("abort_bout", bout4, 0);
    nb = 0;
    for (int i = 0; i < 8; i++) begin
      nb += int'(done4);
      tick();
    end
    chk("abort_no_done", nb, 0);
    run4("a7b2bin1", 4'd7, 4'd2, 1'b1, 4'd4, 1'b0);

    // exhaustive, start held high, operands scrambled while busy
    start4 = 1'b1;
    prev = 0;
    for (int n = 0; n < 512; n++) begin
      ca = 4'(n >> 5); cb = 4'(n >> 1); cbin = n[0];
      a4 = ca; b4 = cb; bin4 = cbin;
      for (int i = 0; i < 10; i++) begin
        if (busy4) break;
        tick();
      end
      a4 = 4'($urandom); b4 = 4'($urandom); bin4 = 1'($urandom);
      for (int i = 0; i < 10; i++) begin
        if (done4) break;
        chk("ex_excl", busy4 & done4, 0);
        tick();
      end
      t = {1'b0, ca} - {1'b0, cb} - {4'd0, cbin};
      chk("ex_done", done4, 1);
      chk("ex_diff", diff4, t[3:0]);
      chk("ex_bout", bout4, t[4]);
      if (n > 0) chk("ex_spacing", cyc - prev, 6);
      prev = cyc;
    end
    start4 = 1'b0;
    tick();
    tick();

    a8 = 8'h00; b8 = 8'h01; bin8 = 1'b0; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    a8 = 8'h55; b8 = 8'h11;
    nb = 0;
    for (int i = 0; i < 20; i++) begin
      if (done8) break;
      nb += int'(busy8);
      tick();
    end
    chk("w8_busy_cycles", nb, 8);
    chk("w8_done", done8, 1);
    chk("w8_diff", diff8, 8'hFF);
    chk("w8_bout", bout8, 1);
    tick();
    chk("w8_done_one_cycle", done8, 0);
    chk("w8_diff_hold", diff8, 8'hFF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
